// File: rtl/tlul_pkg.sv
// TL-UL channel typedefs shared by hosts, devices and crossbar glue.
// Latency: n/a (types only).
// Backpressure: a_ready travels in d2h and d_ready travels in h2d, following valid/ready.
package tlul_pkg;

    localparam int TL_AW  = 32;
    localparam int TL_DW  = 32;
    localparam int TL_AIW = 8;
    localparam int TL_DIW = 1;
    localparam int TL_DBW = TL_DW / 8;
    localparam int TL_SZW = 2;

    typedef enum logic [2:0] {
        PutFullData    = 3'h0,
        PutPartialData = 3'h1,
        Get            = 3'h4
    } tl_a_op_e;

    typedef enum logic [2:0] {
        AccessAck     = 3'h0,
        AccessAckData = 3'h1
    } tl_d_op_e;

    typedef struct packed {
        logic              a_valid;
        tl_a_op_e          a_opcode;
        logic [2:0]        a_param;
        logic [TL_SZW-1:0] a_size;
        logic [TL_AIW-1:0] a_source;
        logic [TL_AW-1:0]  a_address;
        logic [TL_DBW-1:0] a_mask;
        logic [TL_DW-1:0]  a_data;
        logic              d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic              d_valid;
        tl_d_op_e          d_opcode;
        logic [2:0]        d_param;
        logic [TL_SZW-1:0] d_size;
        logic [TL_AIW-1:0] d_source;
        logic [TL_DIW-1:0] d_sink;
        logic [TL_DW-1:0]  d_data;
        logic              d_error;
        logic              a_ready;
    } tl_d2h_t;

endpackage

// File: rtl/tlul_host_arb_fifo.sv
// Synchronous FIFO that holds the host index of each accepted request.
// Latency: one cycle from push to visibility at the head; head is read combinationally.
// Backpressure: a push while full or a pop while empty is ignored; full_o/empty_o let the caller gate.
// Ports: clk_i/rst_ni clock and async reset; push_i/wdata_i write side; pop_i/rdata_o read side;
//        full_o, empty_o, count_o occupancy status.
module tlul_host_arb_fifo #(
    parameter int Width = 2,
    parameter int Depth = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       push_i,
    input  logic [Width-1:0]           wdata_i,
    input  logic                       pop_i,
    output logic [Width-1:0]           rdata_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(Depth+1)-1:0] count_o
);

    localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int CntW = $clog2(Depth + 1);

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CntW'(Depth));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Explicit wrap so depths that are not a power of two still cycle correctly.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            wr_ptr_d = (wr_ptr_q == PtrW'(Depth - 1)) ? '0 : wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = (rd_ptr_q == PtrW'(Depth - 1)) ? '0 : rd_ptr_q + 1'b1;
        end
        count_d = count_q + CntW'(do_push) - CntW'(do_pop);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: an entry is only read after it has been written.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/tlul_host_arb.sv
// Shares one TL-UL device port between NumHosts hosts: round-robin A grant, in-order D routing.
// Latency: zero cycles on A and D; pointer, lock and index FIFO update on the edge after a handshake.
// Backpressure: grant is locked while the device stalls; a full index FIFO withholds a_valid/a_ready.
// Ports: tl_h_i/tl_h_o host sockets; tl_d_o/tl_d_i device socket;
//        outstanding_o FIFO occupancy, idle_o no traffic, err_o sticky unexpected-response flag.
module tlul_host_arb #(
    parameter int NumHosts       = 4,
    parameter int MaxOutstanding = 4
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  tlul_pkg::tl_h2d_t                   tl_h_i [NumHosts],
    output tlul_pkg::tl_d2h_t                   tl_h_o [NumHosts],
    output tlul_pkg::tl_h2d_t                   tl_d_o,
    input  tlul_pkg::tl_d2h_t                   tl_d_i,
    output logic [$clog2(MaxOutstanding+1)-1:0] outstanding_o,
    output logic                                idle_o,
    output logic                                err_o
);

    import tlul_pkg::*;

    localparam int IdxW = $clog2(NumHosts);
    localparam int CntW = $clog2(MaxOutstanding + 1);

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } lock_state_e;

    lock_state_e     lock_state_q, lock_state_d;
    logic [IdxW-1:0] lock_idx_q, lock_idx_d;
    logic [IdxW-1:0] last_q, last_d;
    logic            err_q, err_d;

    logic            rr_vld;
    logic [IdxW-1:0] rr_idx;
    logic            win_vld;
    logic [IdxW-1:0] win_idx;
    logic            dev_a_vld;
    logic            dev_d_rdy;
    logic            accept;
    logic            a_ready_ok;
    logic            any_a_vld;

    logic            fifo_full, fifo_empty;
    logic [IdxW-1:0] head_idx;
    logic [CntW-1:0] fifo_count;
    logic            fifo_pop;

    // Round-robin search: walk offsets from far to near so the nearest requester
    // above last_q is the final (winning) assignment.
    always_comb begin
        rr_vld    = 1'b0;
        rr_idx    = '0;
        any_a_vld = 1'b0;
        for (int off = NumHosts; off >= 1; off--) begin
            if (tl_h_i[(int'(last_q) + off) % NumHosts].a_valid) begin
                rr_vld = 1'b1;
                rr_idx = IdxW'((int'(last_q) + off) % NumHosts);
            end
        end
        for (int i = 0; i < NumHosts; i++) begin
            any_a_vld = any_a_vld | tl_h_i[i].a_valid;
        end
    end

    assign win_vld    = (lock_state_q == LOCKED) || rr_vld;
    assign win_idx    = (lock_state_q == LOCKED) ? lock_idx_q : rr_idx;
    // A full FIFO hides the request from the device entirely, so it can never lock.
    assign dev_a_vld  = win_vld && tl_h_i[win_idx].a_valid && !fifo_full;
    assign a_ready_ok = tl_d_i.a_ready && !fifo_full;
    assign accept     = dev_a_vld && tl_d_i.a_ready;

    // With nothing outstanding any response is unexpected: sink it so the device never hangs.
    assign dev_d_rdy  = fifo_empty ? 1'b1 : tl_h_i[head_idx].d_ready;
    assign fifo_pop   = tl_d_i.d_valid && dev_d_rdy && !fifo_empty;

    always_comb begin
        tl_d_o         = tl_h_i[win_idx];
        tl_d_o.a_valid = dev_a_vld;
        tl_d_o.d_ready = dev_d_rdy;
    end

    always_comb begin
        for (int i = 0; i < NumHosts; i++) begin
            tl_h_o[i] = '0;
            if (!fifo_empty && (head_idx == IdxW'(i))) begin
                tl_h_o[i] = tl_d_i;
            end
            tl_h_o[i].a_ready = win_vld && (win_idx == IdxW'(i)) && a_ready_ok;
        end
    end

    // Lock FSM plus pointer and error next-state.
    always_comb begin
        lock_state_d = lock_state_q;
        lock_idx_d   = lock_idx_q;
        last_d       = last_q;
        err_d        = err_q;
        unique case (lock_state_q)
            UNLOCKED: begin
                if (dev_a_vld && !tl_d_i.a_ready) begin
                    lock_state_d = LOCKED;
                    lock_idx_d   = win_idx;
                end
            end
            LOCKED: begin
                if (accept) begin
                    lock_state_d = UNLOCKED;
                end
            end
            default: lock_state_d = UNLOCKED;
        endcase
        if (accept) begin
            last_d = win_idx;
        end
        if (tl_d_i.d_valid && fifo_empty) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lock_state_q <= UNLOCKED;
            lock_idx_q   <= '0;
            last_q       <= IdxW'(NumHosts - 1);
            err_q        <= 1'b0;
        end else begin
            lock_state_q <= lock_state_d;
            lock_idx_q   <= lock_idx_d;
            last_q       <= last_d;
            err_q        <= err_d;
        end
    end

    tlul_host_arb_fifo #(
        .Width (IdxW),
        .Depth (MaxOutstanding)
    ) u_idx_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (accept),
        .wdata_i (win_idx),
        .pop_i   (fifo_pop),
        .rdata_o (head_idx),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign outstanding_o = fifo_count;
    assign idle_o        = fifo_empty && !any_a_vld;
    assign err_o         = err_q;

endmodule

// File: doc/tlul_host_arb.md
# tlul_host_arb

Shares one downstream TL-UL device port between `NumHosts` upstream TL-UL hosts in the main crossbar fabric. A-channel requests are granted round-robin, with the grant held stable while the device back-pressures. The index of each accepted request's host is queued so that in-order D-channel responses are routed back to the issuing host. It sits between host-side crossbar ports and a single device socket, and also reports outstanding count, idle and a sticky protocol error.

## Interface
- `NumHosts`, default 4: number of upstream hosts, minimum 2.
- `MaxOutstanding`, default 4: maximum accepted-but-unanswered requests (host-index FIFO depth), minimum 1.
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  asynchronous active-low reset.
- `tl_h_i`  in  `tlul_pkg::tl_h2d_t[NumHosts]`  host requests and host `d_ready`.
- `tl_h_o`  out  `tlul_pkg::tl_d2h_t[NumHosts]`  host responses and host `a_ready`.
- `tl_d_o`  out  `tlul_pkg::tl_h2d_t`  request to device.
- `tl_d_i`  in  `tlul_pkg::tl_d2h_t`  response from device.
- `outstanding_o`  out  `$clog2(MaxOutstanding+1)`  current FIFO occupancy.
- `idle_o`  out  1  high when occupancy is 0 and no host asserts `a_valid`.
- `err_o`  out  1  sticky: a D response arrived with an empty FIFO; cleared only by reset.

## Operation
- **State**
  - round-robin pointer `last_q` (index of last granted host); reset value `NumHosts-1`, so host 0 wins first.
  - lock flag `lock_q` plus locked index `lock_idx_q`.
  - host-index FIFO.
  - `err_q`.
- **Arbitration, when `lock_q`=0**
  - Winner is the first requesting host searching upward from `last_q+1`, wrapping modulo `NumHosts`.
  - No requester means no winner, and `tl_d_o.a_valid`=0.
- **Arbitration, when `lock_q`=1**: winner is `lock_idx_q`, regardless of other requests.
- **A-channel forwarding**
  - All `tl_d_o` A fields are muxed from the winner; `a_source` passes unmodified.
  - `tl_d_o.a_valid` = winner `a_valid` AND NOT fifo_full.
  - Winner `a_ready` = `tl_d_i.a_ready` AND NOT fifo_full. All other hosts see `a_ready`=0.
- **Lock FSM** (two states, UNLOCKED/LOCKED)
  - UNLOCKED→LOCKED when `tl_d_o.a_valid`=1 and `tl_d_i.a_ready`=0; captures the winner index.
  - LOCKED→UNLOCKED on handshake.
  - A full FIFO does not lock, because `a_valid` is not presented downstream.
- **Accept** (`tl_d_o.a_valid && tl_d_i.a_ready`)
  - Push winner index into the FIFO.
  - Update `last_q` to the winner.
- **D channel**
  - When the FIFO is non-empty, head index h selects the route.
  - `tl_h_o[h]` D fields = `tl_d_i` D fields; `tl_d_o.d_ready` = `tl_h_i[h].d_ready`.
  - All other hosts see `d_valid`=0.
  - Pop on `tl_d_i.d_valid && tl_d_o.d_ready`.
- **D response with empty FIFO**
  - `tl_d_o.d_ready`=1, so the response is consumed and dropped.
  - No host sees `d_valid`.
  - `err_q` sets.
- **Device ordering**: the device returns responses in request order; this is a requirement on the attached device.

## Timing
- **Latency**: A and D paths are combinational, zero cycles. FIFO, pointer and lock update on the `clk_i` edge after the handshake.
- **Outputs in and just after reset**
  - `tl_d_o.a_valid` = OR of all host `a_valid` (FIFO empty, unlocked).
  - `tl_d_o.d_ready`=1.
  - All `tl_h_o.d_valid`=0.
  - `outstanding_o`=0, `err_o`=0.
  - `idle_o`=1 if no host requests.
- **Simultaneous push and pop**
  - Not full: both occur and occupancy is unchanged.
  - Full: the push is blocked regardless of the same-cycle pop, so there is no combinational path from `d_ready` to `a_ready`.
- **Occupancy limit**: occupancy never exceeds `MaxOutstanding`.
- **Pointer wrap**: the pointer wraps from `NumHosts-1` to 0.
- **Locked host drops `a_valid`**: this is a protocol violation. The lock persists, `tl_d_o.a_valid` follows the host, and no other host is granted until a handshake.
- **Reset mid-transaction**
  - Asynchronously clears FIFO, lock, pointer and error.
  - In-flight responses arriving after reset are dropped and set `err_o`.

## Structure
- TL-UL typedefs come from `tlul_pkg`; no new package.
- One sub-module, `tlul_host_arb_fifo`: a synchronous FIFO of width `$clog2(NumHosts)` and depth `MaxOutstanding`, with full, empty and count outputs.
- The round-robin arbiter and lock FSM stay in the top module.

## Test plan
- **Fairness**: all 4 hosts request continuously with device `a_ready`=1 and instant responses → grants issue in order 0,1,2,3,0 with one accept per cycle.
- **Lock under back-pressure**: host 1 is granted and device `a_ready` is held low for 3 cycles while host 2 also requests → address and data stay from host 1 for all 3 cycles; host 2 is granted the cycle after the handshake.
- **Full FIFO**: `MaxOutstanding`=4, 4 accepts with no responses → `outstanding_o`=4, `tl_d_o.a_valid`=0, all `a_ready`=0. One response in → 3. The next request is accepted the following cycle.
- **Response routing**: requests accepted from hosts 2, 0, 3 → three responses reach hosts 2, 0, 3 in that order. Host 0 holding `d_ready`=0 stalls `tl_d_o.d_ready`.
- **Unexpected response**: `d_valid` with an empty FIFO → `tl_d_o.d_ready`=1, no host `d_valid`, `err_o`=1 thereafter until `rst_ni` is asserted.
- **Reset mid-operation**: `rst_ni` asserted with 2 outstanding and a lock held → after reset `outstanding_o`=0, the lock is released and host 0 has first priority.
